// File: rtl/fp_mul.sv
// fp_mul: IEEE-754 binary32 multiplier, operand register + 2 compute stages.
// Define ROUND_NEAREST_EN for round-to-nearest-even; default build truncates.
module fp_mul (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        out_valid,
    output logic [31:0] result,
    output logic        overflow,
    output logic        underflow
);

    typedef struct packed {
        logic        sign;
        logic        nan;
        logic        inf;
        logic        zero;
        logic [9:0]  exp;
        logic [47:0] prod;
    } s1_t;

    logic        v0;
    logic        v1;
    logic [31:0] a0;
    logic [31:0] b0;
    s1_t         s1_d;
    s1_t         s1_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v0 <= 1'b0;
            a0 <= '0;
            b0 <= '0;
        end else begin
            v0 <= in_valid;
            if (in_valid) begin
                a0 <= A;
                b0 <= B;
            end
        end
    end

    logic [7:0]  ea;
    logic [7:0]  eb;
    logic [22:0] fa;
    logic [22:0] fb;
    logic        inf_a;
    logic        inf_b;
    logic        zero_a;
    logic        zero_b;

    assign ea     = a0[30:23];
    assign eb     = b0[30:23];
    assign fa     = a0[22:0];
    assign fb     = b0[22:0];
    assign inf_a  = (ea == 8'hFF) && (fa == '0);
    assign inf_b  = (eb == 8'hFF) && (fb == '0);
    // denormal operands count as zero
    assign zero_a = (ea == 8'h00);
    assign zero_b = (eb == 8'h00);

    always_comb begin
        s1_d.sign = a0[31] ^ b0[31];
        s1_d.nan  = ((ea == 8'hFF) && (fa != '0)) ||
                    ((eb == 8'hFF) && (fb != '0)) ||
                    (inf_a && zero_b) || (zero_a && inf_b);
        s1_d.inf  = inf_a || inf_b;
        s1_d.zero = zero_a || zero_b;
        s1_d.exp  = {2'b00, ea} + {2'b00, eb} - 10'd127;
        s1_d.prod = 48'({1'b1, fa}) * 48'({1'b1, fb});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1   <= 1'b0;
            s1_q <= '0;
        end else begin
            v1 <= v0;
            if (v0) begin
                s1_q <= s1_d;
            end
        end
    end

    logic [23:0] mant;
    logic [9:0]  en;
    logic [9:0]  ef;
    logic        g;
    logic        stk;
    logic        inc;
    logic [24:0] mr;
    logic [22:0] frac;

    always_comb begin
        if (s1_q.prod[47]) begin
            mant = s1_q.prod[47:24];
            g    = s1_q.prod[23];
            stk  = |s1_q.prod[22:0];
            en   = s1_q.exp + 10'd1;
        end else begin
            mant = s1_q.prod[46:23];
            g    = s1_q.prod[22];
            stk  = |s1_q.prod[21:0];
            en   = s1_q.exp;
        end
    end

`ifdef ROUND_NEAREST_EN
    assign inc = g & (stk | mant[0]);
`else
    logic unused_rnd;
    assign unused_rnd = g ^ stk;
    assign inc = 1'b0;
`endif

    // rounding carry-out leaves 1.000..0, so shift and bump exponent
    assign mr   = {1'b0, mant} + 25'(inc);
    assign ef   = mr[24] ? en + 10'd1 : en;
    assign frac = mr[24] ? mr[23:1] : mr[22:0];

    logic [31:0] res_d;
    logic        ovf_d;
    logic        unf_d;

    always_comb begin
        res_d = '0;
        ovf_d = 1'b0;
        unf_d = 1'b0;
        if (s1_q.nan) begin
            res_d = 32'h7FC0_0000;
        end else if (s1_q.inf) begin
            res_d = {s1_q.sign, 8'hFF, 23'h0};
        end else if (s1_q.zero) begin
            res_d = {s1_q.sign, 31'h0};
        end else if ($signed(ef) >= 10'sd255) begin
            res_d = {s1_q.sign, 8'hFF, 23'h0};
            ovf_d = 1'b1;
        end else if ($signed(ef) <= 10'sd0) begin
            res_d = {s1_q.sign, 31'h0};
            unf_d = 1'b1;
        end else begin
            res_d = {s1_q.sign, ef[7:0], frac};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            out_valid <= v1;
            if (v1) begin
                result    <= res_d;
                overflow  <= ovf_d;
                underflow <= unf_d;
            end
        end
    end

endmodule

// File: tb/tb_fp_mul.sv
// tb_fp_mul: table vectors, random ops vs arithmetic model, reset cases.
// Honours ROUND_NEAREST_EN the same way as the design.
module tb_fp_mul;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        out_valid;
    logic [31:0] result;
    logic        overflow;
    logic        underflow;

    fp_mul dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .A         (a),
        .B         (b),
        .out_valid (out_valid),
        .result    (result),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [31:0] res;
        logic        ovf;
        logic        unf;
        string       tag;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        ovf;
        logic        unf;
        string       tag;
    } vec_t;

    exp_t q[$];
    exp_t last;
    vec_t tbl[$];
    int   n_chk = 0;
    int   n_fail = 0;

    function automatic exp_t model(input logic [31:0] x, input logic [31:0] y);
        exp_t        r;
        logic [7:0]  ex;
        logic [7:0]  ey;
        logic [22:0] fx;
        logic [22:0] fy;
        logic        s;
        logic [63:0] p;
        logic [63:0] m;
        int          e;
        int          sh;
        bit          nx, ny, ix, iy, zx, zy;
`ifdef ROUND_NEAREST_EN
        logic [63:0] rem;
        logic [63:0] half;
`endif
        ex = x[30:23]; ey = y[30:23];
        fx = x[22:0];  fy = y[22:0];
        s  = x[31] ^ y[31];
        nx = (ex == 8'hFF) && (fx != 0);
        ny = (ey == 8'hFF) && (fy != 0);
        ix = (ex == 8'hFF) && (fx == 0);
        iy = (ey == 8'hFF) && (fy == 0);
        zx = (ex == 0);
        zy = (ey == 0);
        r.v = 1'b1; r.ovf = 1'b0; r.unf = 1'b0; r.tag = "random";
        if (nx || ny || (ix && zy) || (zx && iy)) begin
            r.res = 32'h7FC0_0000;
        end else if (ix || iy) begin
            r.res = {s, 8'hFF, 23'h0};
        end else if (zx || zy) begin
            r.res = {s, 31'h0};
        end else begin
            p  = 64'({1'b1, fx}) * 64'({1'b1, fy});
            e  = int'(ex) + int'(ey) - 127;
            sh = (p >= 64'h8000_0000_0000) ? 24 : 23;
            e  = e + sh - 23;
            m  = p >> sh;
`ifdef ROUND_NEAREST_EN
            rem  = p - (m << sh);
            half = 64'd1 << (sh - 1);
            if (rem > half || (rem == half && m[0])) m = m + 1;
`endif
            if (m == 64'h100_0000) begin
                m = m >> 1;
                e = e + 1;
            end
            if (e >= 255) begin
                r.res = {s, 8'hFF, 23'h0};
                r.ovf = 1'b1;
            end else if (e <= 0) begin
                r.res = {s, 31'h0};
                r.unf = 1'b1;
            end else begin
                r.res = {s, e[7:0], m[22:0]};
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] rnd_op();
        logic [7:0]  e;
        logic [22:0] f;
        int          c;
        c = $urandom_range(0, 9);
        case (c)
            0:       e = 8'h00;
            1:       e = 8'hFF;
            2:       e = 8'($urandom_range(1, 40));
            3:       e = 8'($urandom_range(215, 254));
            default: e = 8'($urandom_range(100, 154));
        endcase
        f = 23'($urandom);
        if ($urandom_range(0, 3) == 0) f = '0;
        return {1'($urandom), e, f};
    endfunction

    task automatic check_now(input string tag, input logic v, input logic [31:0] r,
                             input logic o, input logic u);
        n_chk++;
        if (out_valid !== v || result !== r || overflow !== o || underflow !== u) begin
            n_fail++;
            $display("FAIL %s: got v=%0b res=%08h ovf=%0b unf=%0b, want v=%0b res=%08h ovf=%0b unf=%0b",
                     tag, out_valid, result, overflow, underflow, v, r, o, u);
        end
    endtask

    task automatic preload();
        exp_t idle;
        idle.v = 1'b0; idle.res = '0; idle.ovf = 1'b0; idle.unf = 1'b0;
        idle.tag = "idle";
        q.delete();
        last = idle;
        repeat (3) q.push_back(idle);
    endtask

    // output seen at a negedge belongs to inputs driven three negedges earlier
    task automatic step(input logic v, input logic [31:0] x, input logic [31:0] y,
                        input exp_t e);
        exp_t h;
        exp_t n;
        @(negedge clk);
        h = q.pop_front();
        if (h.v) last = h;
        check_now(h.tag, h.v, last.res, last.ovf, last.unf);
        in_valid = v;
        a = x;
        b = y;
        n = e;
        n.v = v;
        if (!v) n.tag = "bubble";
        q.push_back(n);
    endtask

    task automatic add_vec(input logic [31:0] x, input logic [31:0] y, input logic [31:0] r,
                           input logic o, input logic u, input string tag);
        vec_t t;
        t.a = x; t.b = y; t.res = r; t.ovf = o; t.unf = u; t.tag = tag;
        tbl.push_back(t);
    endtask

    task automatic bubble();
        exp_t e;
        e.v = 1'b0; e.res = '0; e.ovf = 1'b0; e.unf = 1'b0; e.tag = "bubble";
        step(1'b0, $urandom, $urandom, e);
    endtask

    task automatic op(input logic [31:0] x, input logic [31:0] y);
        step(1'b1, x, y, model(x, y));
    endtask

    initial begin
        logic [31:0] rnd_exp;
        exp_t        e;
`ifdef ROUND_NEAREST_EN
        rnd_exp = 32'h3FC0_0002;
`else
        rnd_exp = 32'h3FC0_0001;
`endif
        add_vec(32'h3F800000, 32'h3F800000, 32'h3F800000, 0, 0, "one_x_one");
        add_vec(32'h3F800000, 32'h3FC00000, 32'h3FC00000, 0, 0, "one_x_1p5");
        add_vec(32'hBFA00000, 32'h3FC00000, 32'hBFF00000, 0, 0, "neg_1p25_x_1p5");
        add_vec(32'h7F000000, 32'h7F000000, 32'h7F800000, 1, 0, "overflow");
        add_vec(32'hFF000000, 32'h7F000000, 32'hFF800000, 1, 0, "neg_overflow");
        add_vec(32'h00800000, 32'h00800000, 32'h00000000, 0, 1, "underflow");
        add_vec(32'h00800000, 32'h3F000000, 32'h00000000, 0, 1, "underflow_edge");
        add_vec(32'h00800000, 32'h40000000, 32'h01000000, 0, 0, "min_norm_x2");
        add_vec(32'h7F7FFFFF, 32'h3F800000, 32'h7F7FFFFF, 0, 0, "max_norm_x1");
        add_vec(32'h7F800000, 32'h00000000, 32'h7FC00000, 0, 0, "inf_x_zero");
        add_vec(32'h7F800000, 32'h00000005, 32'h7FC00000, 0, 0, "inf_x_denorm");
        add_vec(32'h7FC00001, 32'h3F800000, 32'h7FC00000, 0, 0, "nan_in");
        add_vec(32'hFF800000, 32'h40000000, 32'hFF800000, 0, 0, "neginf_x_2");
        add_vec(32'h80000000, 32'h40A00000, 32'h80000000, 0, 0, "negzero_x_5");
        add_vec(32'h00000001, 32'h3F800000, 32'h00000000, 0, 0, "denorm_daz");
        add_vec(32'h3F800001, 32'h3FC00000, rnd_exp, 0, 0, "round_tie");

        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 check_now("reset", 1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        preload();

        foreach (tbl[i]) begin
            e.v = 1'b1; e.res = tbl[i].res; e.ovf = tbl[i].ovf; e.unf = tbl[i].unf;
            e.tag = tbl[i].tag;
            step(1'b1, tbl[i].a, tbl[i].b, e);
        end
        repeat (4) bubble();

        op(32'h40000000, 32'h40400000);
        bubble();
        op(32'h3F800000, 32'hC0000000);
        op(32'h41200000, 32'h41200000);
        repeat (4) bubble();

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) != 0) op(rnd_op(), rnd_op());
            else bubble();
        end
        repeat (4) bubble();

        op(32'h40000000, 32'h40000000);
        op(32'h40400000, 32'h40400000);
        op(32'h40800000, 32'h40800000);
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1 check_now("mid_reset", 1'b0, 32'h0, 1'b0, 1'b0);
        @(posedge clk);
        #1 check_now("reset_hold", 1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        preload();
        bubble();
        op(32'h3F800000, 32'h3FC00000);
        repeat (4) bubble();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
